// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: funct3 codes, FSM states,
// and the alignment / funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  // Unsigned variants exist only for loads.
  function automatic logic is_legal(
    input logic       we,
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr[0];
      F3_W:    ok = (addr == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: load extract/extend and store lane merge.
// Ports: funct3, addr[1:0], rdata/base/wdata in; load_data, merged out.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] base,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    sh      = {addr, 3'b000};
    shifted = rdata >> sh;
    b       = shifted[7:0];
    h       = addr[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{b[7]}}, b};
      F3_BU:   load_data = {24'b0, b};
      F3_H:    load_data = {{16{h[15]}}, h};
      F3_HU:   load_data = {16'b0, h};
      default: load_data = rdata;
    endcase

    merged = wdata;
    case (funct3[1:0])
      2'd0: merged = (base & ~(32'hFF << sh))
                   | ({24'b0, wdata[7:0]} << sh);
      2'd1: merged = addr[1]
                   ? {wdata[15:0], base[15:0]}
                   : {base[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequences load/store requests onto a word-only data memory,
// with RMW for SB/SH. Ports: req_* in, rsp_* out, mem_* to memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state, nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       base_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              legal;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  lsu_lane u_lane (
    .funct3    (f3_q),
    .addr      (addr_q[1:0]),
    .rdata     (mem_rdata),
    .base      (base_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    legal  = is_legal(req_we, req_funct3, req_addr[1:0]);
    accept = req_valid && (state == S_IDLE);
    nxt    = state;
    case (state)
      S_IDLE:
        if (req_valid) begin
          if (!legal)                   nxt = S_RESP;
          else if (!req_we)             nxt = S_LOAD;
          else if (req_funct3 == F3_W)  nxt = S_WRITE;
          else                          nxt = S_READ;
        end
      S_LOAD:  nxt = S_RESP;
      S_READ:  nxt = S_WRITE;
      S_WRITE: nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase

    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP) && !RST;
    // A reset landing on WRITE must not reach the memory.
    mem_we    = (state == S_WRITE) && !RST;
    mem_wdata = (state == S_WRITE) ? merged : 32'b0;
    mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    rsp_rdata = rdata_q;
    rsp_error = err_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      base_q  <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (!legal) begin
          rdata_q <= 32'b0;
          err_q   <= 1'b1;
        end
      end
      case (state)
        S_LOAD: begin
          rdata_q <= load_data;
          err_q   <= 1'b0;
        end
        S_READ: base_q <= mem_rdata;
        S_WRITE: begin
          rdata_q <= 32'b0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed plus random requests
// against a word-array memory and an arithmetic reference model.
module tb_load_store_unit;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic        mem_init;

  int vectors;
  int miscompares;

  load_store_unit #(.ADDR_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A3C96E1;
  endfunction

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] wdata);
    int          size;
    int          off;
    int          lat;
    int          nwe;
    logic        bad_f3;
    logic        err;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    logic [31:0] exp_rd;

    size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad_f3 = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    off    = int'(addr % 4);
    err    = bad_f3 || ((addr % size) != 0);
    lat    = err ? 1 : (we && f3 != 3'd2) ? 3 : 2;
    word   = ref_mem[addr[5:2]];
    exp_rd = 32'b0;
    if (!err && !we) begin
      if (size == 4) exp_rd = word;
      else begin
        mask = (size == 1) ? 32'hFF : 32'hFFFF;
        v = (word >> (8 * off)) & mask;
        if (!f3[2] && v > (mask >> 1)) v = v | ~mask;
        exp_rd = v;
      end
    end
    if (!err && we) begin
      if (size == 4) ref_mem[addr[5:2]] = wdata;
      else begin
        mask = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
        ref_mem[addr[5:2]] = (word & ~mask)
                           | ((wdata << (8 * off)) & mask);
      end
    end

    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom % 64;
    nwe = 0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin
        @(posedge CLK);
        #1;
      end
      if (mem_we) begin
        nwe++;
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      end
      if (k < lat) begin
        chk("rsp_early", {31'b0, rsp_valid}, 32'd0);
      end else begin
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_error", {31'b0, rsp_error}, {31'b0, err});
      end
    end
    chk("we_pulses", 32'(nwe), (we && !err) ? 32'd1 : 32'd0);
    @(posedge CLK);
    #1;
    chk("rsp_once", {31'b0, rsp_valid}, 32'd0);
    chk("mem_word", mem[addr[5:2]], ref_mem[addr[5:2]]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b1;
    mem_init    = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'b0;
    req_addr    = 32'b0;
    req_wdata   = 32'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_error", {31'b0, rsp_error}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    RST      = 1'b0;
    mem_init = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("idle_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("idle_we", {31'b0, mem_we}, 32'd0);
    end

    do_req(1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h08, 32'h0);
    chk("lw_value", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 32'h0B, 32'h0);
    chk("lb_value", rsp_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 3'd4, 32'h0B, 32'h0);
    chk("lbu_value", rsp_rdata, 32'h000000DE);
    do_req(1'b0, 3'd1, 32'h0A, 32'h0);
    chk("lh_value", rsp_rdata, 32'hFFFFDEAD);
    do_req(1'b0, 3'd5, 32'h08, 32'h0);
    chk("lhu_value", rsp_rdata, 32'h0000BEEF);
    do_req(1'b1, 3'd0, 32'h09, 32'h12);
    chk("sb_merge", mem[2], 32'hDEAD12EF);
    do_req(1'b0, 3'd2, 32'h0A, 32'h0);
    do_req(1'b1, 3'd1, 32'h03, 32'hFFFF);
    do_req(1'b0, 3'd3, 32'h00, 32'h0);

    // SH with reset asserted during its WRITE cycle.
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    req_we     = 1'b1;
    req_funct3 = 3'd1;
    req_addr   = 32'h04;
    req_wdata  = 32'h0000A55A;
    req_valid  = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rstmid_we", {31'b0, mem_we}, 32'd0);
    chk("rstmid_rsp", {31'b0, rsp_valid}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rstmid_after_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rstmid_after_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_after_we", {31'b0, mem_we}, 32'd0);
    chk("rstmid_word", mem[1], ref_mem[1]);
    @(posedge CLK);
    #1;
    chk("rstmid_quiet", {31'b0, rsp_valid}, 32'd0);
    chk("rstmid_word2", mem[1], ref_mem[1]);

    for (int n = 0; n < 80; n++) begin
      do_req(1'($urandom % 2), 3'($urandom % 8),
             32'($urandom % 64), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
